stochastic_round_arbiter: RTL and testbench

- Shares one stochastic float-rounding datapath between NUM_REQ requesters.
- Round-robin arbitration selects at most one request per cycle.
- An internal LFSR supplies the random bits for each rounding decision.
- The rounded result is registered on a valid/ready output together with the requester ID.
- Sits between accumulator drain ports and the narrow-float writeback path.

---
 rtl/stochastic_round_pkg.sv | 34 +++
 rtl/stochastic_round_arbiter_lfsr.sv | 38 +++
 rtl/stochastic_round_arbiter.sv | 137 +++++++++++++
 tb/tb_stochastic_round_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stochastic_round_pkg.sv
// Shared types and constants for the stochastic rounding arbiter.
// Default float layout, width helper and Galois LFSR tap masks.
package stochastic_round_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } floatT;

  // Right-shifting Galois masks for maximal-length polynomials
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [31:0] TAPS32 = 32'h8020_0003;
  localparam logic [63:0] TAPS64 = 64'hD800_0000_0000_0000;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic logic [63:0] lfsrTaps(input int w);
    case (w)
      16:      return 64'(TAPS16);
      64:      return TAPS64;
      default: return 64'(TAPS32);
    endcase
  endfunction

endpackage

// File: rtl/stochastic_round_arbiter_lfsr.sv
// Galois LFSR random source; steps once per advance.
// A zero seed is forced to 1 so the register never locks up.
module lfsr_random_source
  import stochastic_round_pkg::*;
#(
  parameter int          W    = 32,
  parameter logic [W-1:0] SEED = 'h1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         advance,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  localparam logic [63:0] TAPS_ALL = lfsrTaps(W);
  localparam logic [W-1:0] TAPS = TAPS_ALL[W-1:0];

  function automatic logic [W-1:0] nonZero(input logic [W-1:0] s);
    return (s == '0) ? W'(1) : s;
  endfunction

  logic [W-1:0] nextState;

  assign nextState = (state >> 1) ^ (state[0] ? TAPS : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= nonZero(SEED);
    end else if (load) begin
      state <= nonZero(seed);
    end else if (advance) begin
      state <= nextState;
    end
  end

endmodule

// File: rtl/stochastic_round_arbiter.sv
// Round-robin arbiter sharing one stochastic float rounder.
// Winner is rounded combinationally and registered on a valid/ready port.
module stochastic_round_arbiter
  import stochastic_round_pkg::*;
#(
  parameter int EXP        = 8,
  parameter int FRAC       = 23,
  parameter int ROUND_BITS = 8,
  parameter int NUM_REQ    = 4,
  parameter int LFSR_W     = 32,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 'h1,
  localparam int DW  = 1 + EXP + FRAC,
  localparam int IDW = clog2(NUM_REQ)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][DW-1:0]          req_data,
  input  logic [NUM_REQ-1:0][ROUND_BITS-1:0]  req_trailing,
  input  logic [NUM_REQ-1:0]                  req_sticky,
  input  logic [NUM_REQ-1:0]                  req_isnan,
  input  logic                                seed_load,
  input  logic [LFSR_W-1:0]                   seed_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DW-1:0]                       out_data,
  output logic [IDW-1:0]                      out_id
);

  typedef struct packed {
    logic            sign;
    logic [EXP-1:0]  exp;
    logic [FRAC-1:0] frac;
  } fpT;

  function automatic logic [IDW-1:0] wrapAdd(
    input logic [IDW-1:0] a,
    input int             b
  );
    int s;
    s = int'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  logic [IDW-1:0]         ptr;
  logic [2*NUM_REQ-1:0]   dblReq;
  logic [NUM_REQ-1:0]     rotReq;
  logic                   anyReq;
  logic [IDW-1:0]         selIdx;
  logic                   slotFree;
  logic                   grant;
  logic [LFSR_W-1:0]      lfsrState;

  // Rotating by the pointer makes index 0 the highest priority
  assign dblReq = {req_valid, req_valid} >> ptr;
  assign rotReq = dblReq[NUM_REQ-1:0];

  always_comb begin
    anyReq = 1'b0;
    selIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!anyReq && rotReq[k]) begin
        anyReq = 1'b1;
        selIdx = wrapAdd(ptr, k);
      end
    end
  end

  assign slotFree = !out_valid || out_ready;
  assign grant    = anyReq && slotFree && !reset;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[selIdx] = 1'b1;
  end

  fpT                    inF;
  fpT                    resF;
  logic [ROUND_BITS-1:0] rnd;
  logic [ROUND_BITS-1:0] trail;
  logic                  roundUp;
  logic [EXP+FRAC-1:0]   sum;

  always_comb begin
    inF     = fpT'(req_data[selIdx]);
    trail   = req_trailing[selIdx];
    rnd     = lfsrState[ROUND_BITS-1:0];
    roundUp = rnd < trail;
    sum     = {inF.exp, inF.frac} + (EXP+FRAC)'(roundUp);
    resF.sign = inF.sign;
    resF.exp  = sum[EXP+FRAC-1:FRAC];
    if (req_isnan[selIdx]) begin
      resF.frac = inF.frac;
    end else if (&resF.exp) begin
      resF.frac = '0;
    end else begin
      resF.frac = sum[FRAC-1:0];
    end
  end

  // Sticky is carried by the sources but plays no part in rounding
  logic unusedBits;
  assign unusedBits = ^{req_sticky, lfsrState};

  lfsr_random_source #(
    .W    (LFSR_W),
    .SEED (LFSR_SEED)
  ) uLfsr (
    .clock   (clock),
    .reset   (reset),
    .advance (grant),
    .load    (seed_load),
    .seed    (seed_data),
    .state   (lfsrState)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else begin
      if (grant) begin
        out_valid <= 1'b1;
        out_data  <= resF;
        out_id    <= selIdx;
        ptr       <= wrapAdd(selIdx, 1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stochastic_round_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and
// randomized traffic against a behavioural reference model.
module tb_stochastic_round_arbiter;

  localparam int N  = 4;
  localparam int RB = 8;
  localparam int LW = 32;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [N-1:0]             reqValid;
  logic [N-1:0]             reqReady;
  logic [N-1:0][DW-1:0]     reqData;
  logic [N-1:0][RB-1:0]     reqTrailing;
  logic [N-1:0]             reqSticky;
  logic [N-1:0]             reqIsnan;
  logic                     seedLoad;
  logic [LW-1:0]            seedData;
  logic                     outValid;
  logic                     outReady;
  logic [DW-1:0]            outData;
  logic [IW-1:0]            outId;

  always #5 clock = ~clock;

  stochastic_round_arbiter #(
    .EXP(8), .FRAC(23), .ROUND_BITS(RB), .NUM_REQ(N),
    .LFSR_W(LW), .LFSR_SEED(32'h1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (reqValid),
    .req_ready    (reqReady),
    .req_data     (reqData),
    .req_trailing (reqTrailing),
    .req_sticky   (reqSticky),
    .req_isnan    (reqIsnan),
    .seed_load    (seedLoad),
    .seed_data    (seedData),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_data     (outData),
    .out_id       (outId)
  );

  int errors = 0;
  int checks = 0;

  bit          mValid;
  logic [31:0] mData;
  int          mId;
  int          mPtr;
  logic [31:0] mLfsr;
  int          lastGrant = -1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] lfsrNext(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  function automatic logic [31:0] roundRef(input logic [31:0] d,
      input logic [7:0] t, input logic nan, input logic [7:0] r);
    longint mag, sum;
    int e;
    logic [22:0] f;
    mag = longint'(d[30:0]);
    sum = (mag + ((r < t) ? 1 : 0)) % (longint'(1) << 31);
    e = int'(sum >> 23);
    f = nan ? d[22:0] : ((e == 255) ? 23'd0 : 23'(sum));
    return {d[31], 8'(e), f};
  endfunction

  function automatic int pickRef();
    int i;
    if (reset) return -1;
    if (mValid && !outReady) return -1;
    for (int k = 0; k < N; k++) begin
      i = (mPtr + k) % N;
      if (reqValid[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    int g;
    #2;
    g = pickRef();
    chk("req_ready", 64'(reqReady), (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge clock);
    if (reset) begin
      mValid = 0; mData = 0; mId = 0; mPtr = 0; mLfsr = 32'h1;
    end else begin
      if (g >= 0) begin
        mData  = roundRef(reqData[g], reqTrailing[g], reqIsnan[g], mLfsr[7:0]);
        mValid = 1;
        mId    = g;
        mPtr   = (g + 1) % N;
      end else if (outReady) begin
        mValid = 0;
      end
      if (seedLoad) mLfsr = (seedData == 0) ? 32'h1 : seedData;
      else if (g >= 0) mLfsr = lfsrNext(mLfsr);
    end
    lastGrant = g;
    #1;
    chk("out_valid", 64'(outValid), 64'(mValid));
    if (mValid) begin
      chk("out_data", 64'(outData), 64'(mData));
      chk("out_id", 64'(outId), 64'(mId));
    end
    @(negedge clock);
  endtask

  task automatic idle();
    reqValid = '0; seedLoad = 0; reset = 0;
  endtask

  task automatic doReset();
    idle(); reset = 1; step(); reset = 0;
  endtask

  typedef struct {
    int          id;
    logic [31:0] seed;
    logic [31:0] data;
    logic [7:0]  trailing;
    logic        isnan;
    logic [31:0] expData;
  } vecT;

  vecT vecs[10];

  initial begin
    vecs[0] = '{0, 32'h0000_0000, 32'h3F80_0000, 8'hFF, 1'b0, 32'h3F80_0001};
    vecs[1] = '{1, 32'h0000_0001, 32'h7F7F_FFFF, 8'h80, 1'b0, 32'h7F80_0000};
    vecs[2] = '{2, 32'h0000_0100, 32'hFFC0_0000, 8'hFF, 1'b1, 32'hFFC0_0000};
    vecs[3] = '{3, 32'h0000_0001, 32'h3F80_0000, 8'h00, 1'b0, 32'h3F80_0000};
    vecs[4] = '{0, 32'h0000_00FF, 32'h3F80_0000, 8'hFF, 1'b0, 32'h3F80_0000};
    vecs[5] = '{1, 32'h0000_00FE, 32'h3F80_0000, 8'hFF, 1'b0, 32'h3F80_0001};
    vecs[6] = '{2, 32'h0000_0001, 32'h3F7F_FFFF, 8'h02, 1'b0, 32'h3F80_0000};
    vecs[7] = '{3, 32'h0000_0005, 32'h4049_0FDA, 8'h05, 1'b0, 32'h4049_0FDA};
    vecs[8] = '{0, 32'h0000_0005, 32'hC049_0FDA, 8'h06, 1'b0, 32'hC049_0FDB};
    vecs[9] = '{1, 32'h1234_5601, 32'hFFFF_FFFF, 8'hFF, 1'b0, 32'h8000_0000};

    reqData = '0; reqTrailing = '0; reqSticky = '0; reqIsnan = '0;
    seedData = '0; outReady = 1;
    idle();
    reset = 1;
    @(negedge clock);
    step();
    chk("reset_ready", 64'(reqReady), 64'd0);
    step();
    reset = 0;
    chk("reset_valid", 64'(outValid), 64'd0);
    chk("reset_data", 64'(outData), 64'd0);
    chk("reset_id", 64'(outId), 64'd0);

    foreach (vecs[v]) begin
      idle();
      seedLoad = 1; seedData = vecs[v].seed;
      step();
      seedLoad = 0;
      reqValid[vecs[v].id]    = 1;
      reqData[vecs[v].id]     = vecs[v].data;
      reqTrailing[vecs[v].id] = vecs[v].trailing;
      reqIsnan[vecs[v].id]    = vecs[v].isnan;
      step();
      chk("vec_data", 64'(outData), 64'(vecs[v].expData));
      chk("vec_id", 64'(outId), 64'(vecs[v].id));
    end
    idle(); reqIsnan = '0;

    // LFSR advances exactly once per grant: r goes 1, 3, 2 from seed 0
    seedLoad = 1; seedData = 0; step(); seedLoad = 0;
    reqValid[0] = 1; reqData[0] = 32'h3F80_0000; reqTrailing[0] = 8'hFF;
    step();
    chk("adv_r1", 64'(outData), 64'h3F80_0001);
    reqTrailing[0] = 8'h03; step();
    chk("adv_r3", 64'(outData), 64'h3F80_0000);
    step();
    chk("adv_r2", 64'(outData), 64'h3F80_0001);

    // Round-robin with all requesters valid
    doReset();
    for (int i = 0; i < N; i++) begin
      reqData[i] = 32'h4000_0000 + 32'(i * 3); reqTrailing[i] = 8'h00;
    end
    reqValid = '1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_id", 64'(outId), 64'(k % N));
      chk("rr_data", 64'(outData), 64'(32'h4000_0000 + 32'((k % N) * 3)));
    end

    // Backpressure: held output, no grants, frozen LFSR
    doReset();
    outReady = 0;
    reqValid = 4'b0001; reqData[0] = 32'h3F00_0000; reqTrailing[0] = 8'h00;
    step();
    reqValid = 4'b0110;
    reqData[1] = 32'h3E00_0000; reqTrailing[1] = 8'h03;
    reqData[2] = 32'h3D00_0000; reqTrailing[2] = 8'h03;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_ready", 64'(reqReady), 64'd0);
      chk("bp_id", 64'(outId), 64'd0);
      chk("bp_data", 64'(outData), 64'h3F00_0000);
    end
    outReady = 1;
    step();
    chk("bp_rel1_id", 64'(outId), 64'd1);
    chk("bp_rel1_data", 64'(outData), 64'h3E00_0000);
    reqValid[1] = 0;
    step();
    chk("bp_rel2_id", 64'(outId), 64'd2);
    chk("bp_rel2_data", 64'(outData), 64'h3D00_0001);

    // Reset while a result is held under backpressure
    idle(); outReady = 0;
    reqValid = 4'b0001; step();
    reqValid = 4'b1100;
    reqData[2] = 32'h3F80_0000; reqTrailing[2] = 8'h02;
    reset = 1; step();
    reset = 0;
    chk("rst_mid_valid", 64'(outValid), 64'd0);
    outReady = 1;
    step();
    chk("rst_mid_id", 64'(outId), 64'd2);
    chk("rst_mid_data", 64'(outData), 64'h3F80_0001);

    // Randomized traffic
    idle();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!reqValid[i] || lastGrant == i) begin
          reqValid[i]  = ($urandom % 2) == 0;
          reqSticky[i] = 1'($urandom);
          reqIsnan[i]  = ($urandom % 8) == 0;
          if (reqIsnan[i])
            reqData[i] = {1'($urandom), 8'hFF, (($urandom % 2) == 0) ? 23'h40_0000 : 23'h0};
          else
            reqData[i] = $urandom;
          case ($urandom % 8)
            0:       reqTrailing[i] = 8'h00;
            1:       reqTrailing[i] = 8'hFF;
            default: reqTrailing[i] = 8'($urandom);
          endcase
        end
      end
      outReady = ($urandom % 4) != 0;
      seedLoad = ($urandom % 20) == 0;
      seedData = (($urandom % 4) == 0) ? 32'h0 : $urandom;
      reset    = ($urandom % 60) == 0;
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
